// File: rtl/softmax_norm_feeder.sv
// Buffers one vector of exponent values while accumulating their saturated sum,
// then replays each element with the frozen sum to the softmax normalizer.
module softmax_norm_feeder #(
    parameter int EXP_FRACTION_BITS = 11,
    parameter int EXP_BITS          = EXP_FRACTION_BITS + 1,
    parameter int SUM_WIDTH         = 18,
    parameter int MAX_N             = 32,
    parameter int N_WIDTH           = $clog2(MAX_N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_BITS-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 hold,
    output logic                 norm_enable,
    output logic [EXP_BITS-1:0]  norm_e_j,
    output logic [SUM_WIDTH-1:0] norm_sum,
    output logic                 norm_last,
    output logic [N_WIDTH-1:0]   vec_len,
    output logic                 sum_sat,
    output logic                 len_err
);

    localparam int ADDR_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t               state, state_next;
    logic [EXP_BITS-1:0]  ebuf [MAX_N];
    logic [N_WIDTH-1:0]   wr_cnt, rd_ptr;
    logic [SUM_WIDTH-1:0] acc, acc_next;
    logic                 ovf, take, vec_end, last_issue;

    // Returns {overflow, clamped sum}; the sum clamps to all-ones on overflow.
    function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [EXP_BITS-1:0]  e);
        logic [SUM_WIDTH:0] raw;
        raw = {1'b0, a} + (SUM_WIDTH + 1)'(e);
        sat_add = raw[SUM_WIDTH] ? {1'b1, {SUM_WIDTH{1'b1}}} : raw;
    endfunction

    assign {ovf, acc_next} = sat_add(acc, in_data);
    assign take       = in_valid & in_ready;
    assign vec_end    = take & (in_last | (wr_cnt == N_WIDTH'(MAX_N - 1)));
    assign last_issue = (state == DRAIN) & ~hold & (rd_ptr == vec_len - N_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (vec_end)    state_next = DRAIN;
            DRAIN:   if (last_issue) state_next = ACCUM;
            default:                 state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (take) ebuf[wr_cnt[ADDR_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            acc         <= '0;
            norm_enable <= 1'b0;
            norm_e_j    <= '0;
            norm_sum    <= '0;
            norm_last   <= 1'b0;
            vec_len     <= '0;
            sum_sat     <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                ACCUM: begin
                    norm_enable <= 1'b0;
                    norm_last   <= 1'b0;
                    if (take) begin
                        wr_cnt  <= wr_cnt + N_WIDTH'(1);
                        acc     <= acc_next;
                        // First element of a vector discards the previous vector's flag.
                        sum_sat <= (wr_cnt == '0) ? ovf : (sum_sat | ovf);
                        if (vec_end) begin
                            norm_sum <= acc_next;
                            vec_len  <= wr_cnt + N_WIDTH'(1);
                            len_err  <= ~in_last;
                        end
                    end
                end
                DRAIN: begin
                    if (hold) begin
                        norm_enable <= 1'b0;
                        norm_last   <= 1'b0;
                    end else begin
                        norm_enable <= 1'b1;
                        norm_e_j    <= ebuf[rd_ptr[ADDR_W-1:0]];
                        norm_last   <= last_issue;
                        if (last_issue) begin
                            wr_cnt <= '0;
                            rd_ptr <= '0;
                            acc    <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + N_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    norm_enable <= 1'b0;
                    norm_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm_feeder.sv
// Scenario bench for softmax_norm_feeder; the sum is narrowed to 12 bits so
// saturation is reachable with short vectors.
module tb_softmax_norm_feeder;

    localparam int EB = 12;
    localparam int SW = 12;
    localparam int NW = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EB-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          hold = 1'b0;
    logic          norm_enable;
    logic [EB-1:0] norm_e_j;
    logic [SW-1:0] norm_sum;
    logic          norm_last;
    logic [NW-1:0] vec_len;
    logic          sum_sat;
    logic          len_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int m_e[$], m_sum[$], m_len[$], m_cyc[$];
    bit m_last[$], m_sat[$], m_rdy[$];
    int acc_q[$];

    softmax_norm_feeder #(.SUM_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .hold(hold),
        .norm_enable(norm_enable), .norm_e_j(norm_e_j), .norm_sum(norm_sum),
        .norm_last(norm_last), .vec_len(vec_len), .sum_sat(sum_sat), .len_err(len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: cyc here is the index of the edge that produced the strobe.
    always @(negedge clk) begin
        if (norm_enable) begin
            m_e.push_back(int'(norm_e_j));
            m_sum.push_back(int'(norm_sum));
            m_len.push_back(int'(vec_len));
            m_last.push_back(norm_last);
            m_sat.push_back(sum_sat);
            m_rdy.push_back(in_ready);
            m_cyc.push_back(cyc);
        end
    end

    function automatic int raw_sum(input int v[$]);
        int s = 0;
        foreach (v[i]) s += v[i];
        return s;
    endfunction

    task automatic clear_mon();
        m_e.delete(); m_sum.delete(); m_len.delete(); m_last.delete();
        m_sat.delete(); m_rdy.delete(); m_cyc.delete(); acc_q.delete();
    endtask

    // Presents one element and returns after the edge that accepts it; in_valid stays high.
    task automatic send(input int d, input bit l);
        bit done = 0;
        int n = 0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = EB'(d); in_last = l;
            if (in_ready) begin done = 1; acc_q.push_back(cyc + 1); end
            @(posedge clk);
            n++;
            if (n > 500) begin
                $display("FAIL send_timeout got in_ready=%0b required 1", in_ready);
                $fatal(1, "handshake never completed");
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input bit rnd_hold, output bit ok);
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (m_e.size() >= n) begin ok = 1; break; end
            hold = rnd_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        hold = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({norm_enable, norm_e_j, norm_sum, norm_last, vec_len, sum_sat, len_err} !== '0
            || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b e=%0d sum=%0d last=%0b len=%0d sat=%0b lerr=%0b rdy=%0b required all 0, rdy=1",
                     norm_enable, norm_e_j, norm_sum, norm_last, vec_len, sum_sat, len_err, in_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int v[$] = '{2048, 1024, 512, 256};
        int t; bit ok;
        clear_mon();
        foreach (v[i]) send(v[i], i == 3);
        idle();
        wait_strobes(4, 0, ok);
        t = acc_q[3];
        checks++;
        if (!ok || m_e.size() != 4) begin
            errors++; $display("FAIL basic_count got %0d strobes required 4", m_e.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (m_e[i] !== v[i] || m_last[i] !== (i == 3) || m_sum[i] !== 3840 || m_len[i] !== 4
                    || m_cyc[i] !== t + 1 + i || m_rdy[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_strobe%0d got e=%0d last=%0b sum=%0d len=%0d edge=%0d rdy=%0b required e=%0d last=%0b sum=3840 len=4 edge=%0d rdy=%0b",
                             i, m_e[i], m_last[i], m_sum[i], m_len[i], m_cyc[i], m_rdy[i], v[i], i == 3, t + 1 + i, i == 3);
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        clear_mon();
        send(4095, 0); send(4095, 1);
        idle();
        wait_strobes(2, 0, ok);
        checks++;
        if (!ok || m_e.size() != 2 || m_sum[1] !== SMAX || m_sat[1] !== 1'b1 || m_sat[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_sum got strobes=%0d sum=%0d sat=%0b required strobes=2 sum=%0d sat=1",
                     m_e.size(), m_e.size() > 1 ? m_sum[1] : -1, m_e.size() > 1 ? m_sat[1] : 1'b0, SMAX);
        end
        checks++;
        if (sum_sat !== 1'b1) begin
            errors++; $display("FAIL sat_sticky got %0b required 1", sum_sat);
        end
        clear_mon();
        send(10, 1);
        idle();
        checks++;
        if (sum_sat !== 1'b0) begin
            errors++; $display("FAIL sat_clear got %0b required 0", sum_sat);
        end
        wait_strobes(1, 0, ok);
    endtask

    task automatic test_overflow();
        bit ok;
        clear_mon();
        for (int i = 0; i < 32; i++) send(100, 0);
        @(negedge clk);
        checks++;
        if (len_err !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_lenerr got len_err=%0b in_ready=%0b required 1/0", len_err, in_ready);
        end
        @(negedge clk);
        checks++;
        if (len_err !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_pulse got len_err=%0b in_ready=%0b required 0/0", len_err, in_ready);
        end
        in_valid = 1'b0;
        wait_strobes(32, 0, ok);
        checks++;
        if (!ok || m_e.size() != 32 || acc_q.size() != 32) begin
            errors++; $display("FAIL ovf_count got %0d strobes %0d accepts required 32/32", m_e.size(), acc_q.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (m_e[i] !== 100 || m_sum[i] !== 3200 || m_len[i] !== 32 || m_last[i] !== (i == 31)
                    || m_cyc[i] !== acc_q[31] + 1 + i) begin
                    errors++;
                    $display("FAIL ovf_strobe%0d got e=%0d sum=%0d len=%0d last=%0b edge=%0d required 100/3200/32/%0b edge=%0d",
                             i, m_e[i], m_sum[i], m_len[i], m_last[i], m_cyc[i], i == 31, acc_q[31] + 1 + i);
                end
            end
        end
    endtask

    task automatic test_hold();
        int v[$];
        int t; bit ok;
        clear_mon();
        for (int i = 0; i < 3; i++) v.push_back($urandom_range(1, 4095));
        foreach (v[i]) send(v[i], i == 2);
        t = acc_q[2];
        idle();
        @(posedge clk);
        @(negedge clk); hold = 1'b1;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            checks++;
            if (norm_enable !== 1'b0 || norm_e_j !== EB'(v[0]) || norm_last !== 1'b0) begin
                errors++;
                $display("FAIL hold_gap%0d got en=%0b e=%0d last=%0b required 0/%0d/0", g, norm_enable, norm_e_j, norm_last, v[0]);
            end
        end
        hold = 1'b0;
        wait_strobes(3, 0, ok);
        checks++;
        if (!ok || m_e.size() != 3) begin
            errors++; $display("FAIL hold_count got %0d required 3", m_e.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (m_e[i] !== v[i] || m_last[i] !== (i == 2) || m_cyc[i] !== t + 1 + i + (i > 0 ? 2 : 0)) begin
                    errors++;
                    $display("FAIL hold_strobe%0d got e=%0d last=%0b edge=%0d required e=%0d last=%0b edge=%0d",
                             i, m_e[i], m_last[i], m_cyc[i], v[i], i == 2, t + 1 + i + (i > 0 ? 2 : 0));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        for (int i = 0; i < 5; i++) send(300 + i, i == 4);
        idle();
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        checks++;
        if ({norm_enable, norm_e_j, norm_sum, norm_last, vec_len, sum_sat, len_err} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got en=%0b e=%0d sum=%0d last=%0b len=%0d required all 0",
                     norm_enable, norm_e_j, norm_sum, norm_last, vec_len);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got %0b required 1", in_ready);
        end
        clear_mon();
        send(2048, 1);
        idle();
        wait_strobes(1, 0, ok);
        checks++;
        if (!ok || m_e.size() != 1 || m_e[0] !== 2048 || m_sum[0] !== 2048 || m_last[0] !== 1'b1 || m_len[0] !== 1) begin
            errors++;
            $display("FAIL rstmid_single got strobes=%0d e=%0d sum=%0d last=%0b required 1/2048/2048/1",
                     m_e.size(), m_e.size() ? m_e[0] : -1, m_e.size() ? m_sum[0] : -1, m_e.size() ? m_last[0] : 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int v[$];
        int s0, s1; bit ok;
        clear_mon();
        for (int i = 0; i < 4; i++) v.push_back($urandom_range(0, 4095));
        s0 = raw_sum(v[0:1]);
        s1 = raw_sum(v[2:3]);
        foreach (v[i]) send(v[i], i % 2 == 1);
        idle();
        wait_strobes(4, 0, ok);
        checks++;
        if (!ok || m_e.size() != 4) begin
            errors++; $display("FAIL b2b_count got %0d required 4", m_e.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (m_e[i] !== v[i] || m_last[i] !== (i % 2 == 1) || m_len[i] !== 2
                    || m_sum[i] !== ((i < 2 ? s0 : s1) > SMAX ? SMAX : (i < 2 ? s0 : s1))) begin
                    errors++;
                    $display("FAIL b2b_strobe%0d got e=%0d last=%0b sum=%0d required e=%0d last=%0b", i, m_e[i], m_last[i], m_sum[i], v[i], i % 2 == 1);
                end
            end
            checks++;
            if (acc_q[2] !== m_cyc[1] + 1) begin
                errors++; $display("FAIL b2b_overlap got accept edge %0d required %0d", acc_q[2], m_cyc[1] + 1);
            end
        end
    endtask

    task automatic test_random();
        int v[$];
        int n, mx, s; bit ok;
        for (int r = 0; r < 8; r++) begin
            clear_mon();
            v.delete();
            n  = (r == 7) ? 32 : $urandom_range(1, 32);
            mx = $urandom_range(0, 1) ? 255 : 4095;
            for (int i = 0; i < n; i++) v.push_back($urandom_range(0, mx));
            s = raw_sum(v);
            foreach (v[i]) send(v[i], i == n - 1);
            idle();
            wait_strobes(n, 1, ok);
            checks++;
            if (!ok || m_e.size() != n) begin
                errors++; $display("FAIL rand%0d_count got %0d required %0d", r, m_e.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (m_e[i] !== v[i] || m_last[i] !== (i == n - 1) || m_len[i] !== n
                        || m_sum[i] !== (s > SMAX ? SMAX : s) || m_sat[i] !== (s > SMAX)) begin
                        errors++;
                        $display("FAIL rand%0d_strobe%0d got e=%0d last=%0b len=%0d sum=%0d sat=%0b required e=%0d last=%0b len=%0d sum=%0d sat=%0b",
                                 r, i, m_e[i], m_last[i], m_len[i], m_sum[i], m_sat[i], v[i], i == n - 1, n, s > SMAX ? SMAX : s, s > SMAX);
                    end
                    checks++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softmax_norm_feeder.md
Name: softmax_norm_feeder

Overview:
- Upstream driver of the softmax normalizer stage.
- Accepts one vector of exp(z_j - z_max) values from the exponent unit over a valid/ready stream, buffers them and accumulates the denominator Σe.
- After the vector ends, replays each buffered e_j with the frozen sum to the normalizer, one element per cycle, with a one-cycle enable strobe per element.

Parameters:
- EXP_FRACTION_BITS, 11, fraction bits of each e_j.
- EXP_BITS, EXP_FRACTION_BITS+1, width of each e_j (unsigned, value in [0,2)).
- SUM_WIDTH, 18, width of the accumulated denominator; same fraction bits as e_j.
- MAX_N, 32, maximum vector length and buffer depth.
- N_WIDTH, $clog2(MAX_N+1), width of the length counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  block can accept an element.
- in_data  input  EXP_BITS  e_j value.
- in_last  input  1  final element of the vector (sampled with in_data).
- hold  input  1  pauses replay while high.
- norm_enable  output  1  one-cycle strobe per replayed element, to normalizer enable.
- norm_e_j  output  EXP_BITS  replayed e_j.
- norm_sum  output  SUM_WIDTH  frozen Σe for the current vector.
- norm_last  output  1  high together with norm_enable on the final element.
- vec_len  output  N_WIDTH  length of the vector being replayed or last replayed.
- sum_sat  output  1  sum saturated during the current or last vector.
- len_err  output  1  one-cycle pulse: MAX_N elements taken without in_last.

Behaviour:
- Reset (async, rst=1): state=ACCUM. All outputs 0 except in_ready=1. Internal wr_cnt, rd_ptr and acc are 0. Buffer contents are don't-care.
- Reset asserted mid-vector or mid-replay discards everything. No partial replay resumes.
- ACCUM state:
  - in_ready=1.
  - On a handshake (in_valid & in_ready): buf[wr_cnt]<=in_data; wr_cnt++; acc<=sat(acc+in_data).
  - If the sum exceeds 2^SUM_WIDTH-1, it clamps to all-ones and sum_sat is set. sum_sat is sticky until the first handshake of the next vector, which clears it.
  - If the handshake has in_last=1, or wr_cnt reaches MAX_N: register norm_sum<=final acc and vec_len<=final count, then go to DRAIN.
  - Forced end of vector (MAX_N reached with in_last=0): len_err=1 for exactly one cycle. Element MAX_N is treated as last.
- DRAIN state:
  - in_ready=0; in_valid is ignored and no data is lost upstream.
  - Each cycle with hold=0, on the next edge: norm_enable<=1, norm_e_j<=buf[rd_ptr], norm_last<=(rd_ptr==vec_len-1), rd_ptr++.
  - Each cycle with hold=1, on the next edge: norm_enable<=0, norm_last<=0; norm_e_j and rd_ptr are unchanged.
  - On the edge that issues the last element: go to ACCUM, clear wr_cnt, rd_ptr and acc. in_ready returns to 1 in that same cycle.
  - The next vector's first element may be accepted while norm_last=1 is visible.
- Outside DRAIN, norm_enable and norm_last are 0.
- norm_sum, vec_len and norm_e_j hold their last values until overwritten. norm_sum is stable for the whole replay of a vector.
- Latency, with the last input accepted at edge T and hold=0: element i drives norm_enable at edge T+1+i. Replay of N elements occupies N consecutive cycles.
- Replay order equals arrival order.
- Arithmetic: acc is unsigned and zero-extended from EXP_BITS, with saturating add. No rounding is applied.
- A vector of length 1 is legal: a single strobe with norm_last=1.
- An all-zero vector is legal and passes norm_sum=0 through.

Test Plan:
1. Length-4 vector: in_data = 2048, 1024, 512, 256, in_last on the 4th, hold=0.
   - Required: norm_sum=3840, vec_len=4.
   - norm_enable high for 4 consecutive cycles starting one cycle after the last accept.
   - norm_e_j = 2048, 1024, 512, 256 in order; norm_last on 256.
   - in_ready low during replay and high again on the edge that issues 256.
2. Saturation: SUM_WIDTH=12, two elements of 4095 with in_last on the second.
   - Required: norm_sum=4095, sum_sat=1.
   - sum_sat clears on the first handshake of the next vector.
3. Length overflow: 32 elements of value 100 with in_last never asserted.
   - Required: len_err pulses one cycle on the 32nd accept.
   - vec_len=32, norm_sum=3200, 32 strobes; the 33rd in_valid is stalled (in_ready=0).
4. Hold during replay: length-3 vector, hold=1 for 2 cycles after the first strobe.
   - Required: strobes separated by a 2-cycle gap.
   - norm_e_j unchanged during the gap; still exactly 3 strobes, the last with norm_last=1.
5. Reset mid-replay: assert rst after the 2nd strobe of a length-5 vector.
   - Required: all outputs 0 immediately, in_ready=1 after reset release.
   - A new length-1 vector of value 2048 yields a single strobe with norm_sum=2048 and norm_last=1.
6. Back-to-back vectors: upstream holds in_valid high continuously across two length-2 vectors.
   - Required: no element dropped or duplicated.
   - The second vector's first element is accepted in the cycle norm_last of the first vector is high.
